// File: rtl/pmi_ram_dq_arbiter.sv
// pmi_ram_dq_arbiter
// Round-robin arbiter that lets two requesters (A and B) share one
// single-port pmi_ram_dq macro. One command per cycle is accepted,
// registered onto the RAM port, and read returns are steered back to the
// requester that issued them.
//
// Ports
//   Clock, Reset          : shared clock, synchronous active-high reset
//   ReqX/WeX/AddrX/DataX  : command from requester X (We: 1 = write, 0 = read)
//   GntX                  : command from X accepted this cycle
//   RdValidX, QX          : read data for X is valid on QX this cycle
//   RamAddress/RamData/RamWE/RamClockEn/RamReset : to the RAM macro
//   RamQ                  : read data from the RAM macro
//
// Handshake: a command transfers on the rising edge where Req & Gnt are both
// high. The requester holds Req/We/Addr/Data stable until Gnt and may drop
// Req only after acceptance. Gnt is purely combinational from Req, the
// priority pointer and Reset. Read data is not back-pressured: RdValid is a
// single-cycle strobe and Q is valid only while it is high.
module pmi_ram_dq_arbiter #(
  parameter int addr_width = 9,
  parameter int data_width = 18,
  parameter int rd_latency = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  ReqA,
  input  logic                  WeA,
  input  logic [addr_width-1:0] AddrA,
  input  logic [data_width-1:0] DataA,
  output logic                  GntA,
  output logic                  RdValidA,
  output logic [data_width-1:0] QA,
  input  logic                  ReqB,
  input  logic                  WeB,
  input  logic [addr_width-1:0] AddrB,
  input  logic [data_width-1:0] DataB,
  output logic                  GntB,
  output logic                  RdValidB,
  output logic [data_width-1:0] QB,
  output logic [addr_width-1:0] RamAddress,
  output logic [data_width-1:0] RamData,
  output logic                  RamWE,
  output logic                  RamClockEn,
  output logic                  RamReset,
  input  logic [data_width-1:0] RamQ
);

  if (rd_latency != 1 && rd_latency != 2) begin : gBadLatency
    $error("pmi_ram_dq_arbiter: rd_latency must be 1 (noreg) or 2 (reg)");
  end

  // Priority pointer: 0 = A wins a tie, 1 = B wins a tie.
  logic prioB;

  // Tag pipeline: stage 0 is the cycle the command sits on the RAM port,
  // stage rd_latency is the cycle the RAM presents its data.
  logic [rd_latency:0] tagValid;
  logic [rd_latency:0] tagOwner;   // 0 = A, 1 = B

  logic readAccepted;
  logic readOwner;

  // Grant logic: lone requester wins, a tie goes to the pointer.
  always_comb begin
    GntA = 1'b0;
    GntB = 1'b0;
    if (!Reset) begin
      GntA = ReqA && (!ReqB || !prioB);
      GntB = ReqB && (!ReqA ||  prioB);
    end
  end

  always_comb begin
    readAccepted = (GntA && !WeA) || (GntB && !WeB);
    readOwner    = GntB;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      prioB      <= 1'b0;
      RamWE      <= 1'b0;
      RamAddress <= '0;
      RamData    <= '0;
      tagValid   <= '0;
      tagOwner   <= '0;
    end else begin
      // Pointer only moves on a grant; idle cycles keep it where it is.
      if (GntA) begin
        prioB <= 1'b1;
      end else if (GntB) begin
        prioB <= 1'b0;
      end

      if (GntA) begin
        RamAddress <= AddrA;
        RamData    <= DataA;
        RamWE      <= WeA;
      end else if (GntB) begin
        RamAddress <= AddrB;
        RamData    <= DataB;
        RamWE      <= WeB;
      end else begin
        RamWE      <= 1'b0;   // address/data hold their last value
      end

      tagValid <= {tagValid[rd_latency-1:0], readAccepted};
      tagOwner <= {tagOwner[rd_latency-1:0], readOwner};
    end
  end

  always_comb begin
    RdValidA   = tagValid[rd_latency] && !tagOwner[rd_latency];
    RdValidB   = tagValid[rd_latency] &&  tagOwner[rd_latency];
    QA         = RamQ;
    QB         = RamQ;
    RamClockEn = 1'b1;   // RAM output pipeline must always advance
    RamReset   = Reset;
  end

endmodule

// File: tb/tb_pmi_ram_dq_arbiter.sv
// Bench for pmi_ram_dq_arbiter. Two instances (rd_latency 2 and 1) receive
// identical stimulus, each with its own behavioural single-port RAM.
module tb_pmi_ram_dq_arbiter;
  localparam int AW = 9;
  localparam int DW = 18;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          reqA, weA, reqB, weB;
  logic [AW-1:0] addrA, addrB;
  logic [DW-1:0] dataA, dataB;

  // rd_latency = 2 instance
  logic          gntA2, gntB2, rdValidA2, rdValidB2, ramWe2, ramCe2, ramRst2;
  logic [DW-1:0] qa2, qb2, ramData2, ramQ2;
  logic [AW-1:0] ramAddr2;
  // rd_latency = 1 instance
  logic          gntA1, gntB1, rdValidA1, rdValidB1, ramWe1, ramCe1, ramRst1;
  logic [DW-1:0] qa1, qb1, ramData1, ramQ1;
  logic [AW-1:0] ramAddr1;

  pmi_ram_dq_arbiter #(.addr_width(AW), .data_width(DW), .rd_latency(2)) dut2 (
    .Clock(clk), .Reset(rst),
    .ReqA(reqA), .WeA(weA), .AddrA(addrA), .DataA(dataA),
    .GntA(gntA2), .RdValidA(rdValidA2), .QA(qa2),
    .ReqB(reqB), .WeB(weB), .AddrB(addrB), .DataB(dataB),
    .GntB(gntB2), .RdValidB(rdValidB2), .QB(qb2),
    .RamAddress(ramAddr2), .RamData(ramData2), .RamWE(ramWe2),
    .RamClockEn(ramCe2), .RamReset(ramRst2), .RamQ(ramQ2)
  );

  pmi_ram_dq_arbiter #(.addr_width(AW), .data_width(DW), .rd_latency(1)) dut1 (
    .Clock(clk), .Reset(rst),
    .ReqA(reqA), .WeA(weA), .AddrA(addrA), .DataA(dataA),
    .GntA(gntA1), .RdValidA(rdValidA1), .QA(qa1),
    .ReqB(reqB), .WeB(weB), .AddrB(addrB), .DataB(dataB),
    .GntB(gntB1), .RdValidB(rdValidB1), .QB(qb1),
    .RamAddress(ramAddr1), .RamData(ramData1), .RamWE(ramWe1),
    .RamClockEn(ramCe1), .RamReset(ramRst1), .RamQ(ramQ1)
  );

  // ---------------- RAM models (normal write mode) ----------------
  logic [DW-1:0] mem2 [0:(1<<AW)-1];
  logic [DW-1:0] mem1 [0:(1<<AW)-1];
  logic [DW-1:0] gold [0:(1<<AW)-1];
  logic [DW-1:0] qRaw2, qReg2, qRaw1;

  always @(posedge clk) begin
    if (ramCe2) begin
      if (ramWe2) mem2[ramAddr2] <= ramData2;
      qRaw2 <= mem2[ramAddr2];
      qReg2 <= ramRst2 ? '0 : qRaw2;
    end
    if (ramCe1) begin
      if (ramWe1) mem1[ramAddr1] <= ramData1;
      qRaw1 <= mem1[ramAddr1];
    end
  end
  assign ramQ2 = qReg2;
  assign ramQ1 = qRaw1;

  // ---------------- scoreboard ----------------
  typedef struct {
    int            due;
    logic          owner;   // 0 = A, 1 = B
    logic [DW-1:0] data;
  } ret_t;
  ret_t exp_q2[$];
  ret_t exp_q1[$];

  logic          expRamWe;
  logic [AW-1:0] expRamAddr;
  logic [DW-1:0] expRamData;
  int cyc = 0;
  int nChecks = 0;
  int nFails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic checkLat(input int lat, input logic vA, input logic vB,
                          input logic [DW-1:0] qa, input logic [DW-1:0] qb,
                          input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic ce, input logic rr);
    ret_t e;
    logic have;
    string s;
    have = 1'b0;
    s = (lat == 2) ? "L2" : "L1";
    if (lat == 2) begin
      if (exp_q2.size() > 0) begin
        if (exp_q2[0].due == cyc) begin
          e = exp_q2.pop_front();
          have = 1'b1;
        end
      end
    end else begin
      if (exp_q1.size() > 0) begin
        if (exp_q1[0].due == cyc) begin
          e = exp_q1.pop_front();
          have = 1'b1;
        end
      end
    end
    chk({"rdValidA_", s}, 32'(vA), 32'(have && !e.owner));
    chk({"rdValidB_", s}, 32'(vB), 32'(have &&  e.owner));
    if (have && !e.owner) chk({"qa_", s}, 32'(qa), 32'(e.data));
    if (have &&  e.owner) chk({"qb_", s}, 32'(qb), 32'(e.data));
    chk({"ramWe_", s},   32'(we),   32'(expRamWe));
    chk({"ramAddr_", s}, 32'(addr), 32'(expRamAddr));
    chk({"ramData_", s}, 32'(data), 32'(expRamData));
    chk({"ramCe_", s},   32'(ce),   32'd1);
    chk({"ramRst_", s},  32'(rr),   32'(rst));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          rst;
    logic          reqA, weA;
    logic [AW-1:0] addrA;
    logic [DW-1:0] dataA;
    logic          reqB, weB;
    logic [AW-1:0] addrB;
    logic [DW-1:0] dataB;
    logic          expGA, expGB;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic ra, input logic wa,
                              input logic [AW-1:0] aa, input logic [DW-1:0] da,
                              input logic rb, input logic wb,
                              input logic [AW-1:0] ab, input logic [DW-1:0] db,
                              input logic ga, input logic gb);
    vec_t v;
    v.rst = r; v.reqA = ra; v.weA = wa; v.addrA = aa; v.dataA = da;
    v.reqB = rb; v.weB = wb; v.addrB = ab; v.dataB = db;
    v.expGA = ga; v.expGB = gb;
    return v;
  endfunction

  function automatic vec_t idle();
    return mk(0, 0, 0, '0, '0, 0, 0, '0, '0, 0, 0);
  endfunction

  // ---------------- driver ----------------
  task automatic step(input vec_t v);
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    rst = v.rst;
    reqA = v.reqA; weA = v.weA; addrA = v.addrA; dataA = v.dataA;
    reqB = v.reqB; weB = v.weB; addrB = v.addrB; dataB = v.dataB;
    @(negedge clk);
    chk("gntA_L2", 32'(gntA2), 32'(v.expGA));
    chk("gntB_L2", 32'(gntB2), 32'(v.expGB));
    chk("gntA_L1", 32'(gntA1), 32'(v.expGA));
    chk("gntB_L1", 32'(gntB1), 32'(v.expGB));
    checkLat(2, rdValidA2, rdValidB2, qa2, qb2, ramWe2, ramAddr2, ramData2, ramCe2, ramRst2);
    checkLat(1, rdValidA1, rdValidB1, qa1, qb1, ramWe1, ramAddr1, ramData1, ramCe1, ramRst1);
    // Expectations for the next cycle.
    if (v.rst) begin
      expRamWe = 1'b0; expRamAddr = '0; expRamData = '0;
      exp_q2.delete();
      exp_q1.delete();
    end else if (v.expGA || v.expGB) begin
      w = v.expGA ? v.weA   : v.weB;
      a = v.expGA ? v.addrA : v.addrB;
      d = v.expGA ? v.dataA : v.dataB;
      expRamWe = w; expRamAddr = a; expRamData = d;
      if (w) begin
        gold[a] = d;
      end else begin
        exp_q2.push_back('{due: cyc + 3, owner: v.expGB, data: gold[a]});
        exp_q1.push_back('{due: cyc + 2, owner: v.expGB, data: gold[a]});
      end
    end else begin
      expRamWe = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // ---------------- test ----------------
  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem2[i] = DW'(i * 37 + 5);
      mem1[i] = DW'(i * 37 + 5);
      gold[i] = DW'(i * 37 + 5);
    end
    rst = 1'b1;
    reqA = 0; weA = 0; addrA = '0; dataA = '0;
    reqB = 0; weB = 0; addrB = '0; dataB = '0;
    expRamWe = 1'b0; expRamAddr = '0; expRamData = '0;
    repeat (2) @(posedge clk);
    #1;

    // A write alone, then A read of the same address.
    vecs.push_back(mk(0, 1, 1, 9'h005, 18'h1234, 0, 0, '0, '0, 1, 0));
    vecs.push_back(idle());
    vecs.push_back(mk(0, 1, 0, 9'h005, 18'h0,    0, 0, '0, '0, 1, 0));
    repeat (4) vecs.push_back(idle());
    // Reset, then continuous contention of reads: A,B,A,B,A,B, then A alone.
    vecs.push_back(mk(1, 0, 0, '0, '0, 0, 0, '0, '0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 9'h020, 18'h0, 1, 0, 9'h030, 18'h0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 9'h021, 18'h0, 1, 0, 9'h030, 18'h0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 9'h021, 18'h0, 1, 0, 9'h031, 18'h0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 9'h022, 18'h0, 1, 0, 9'h031, 18'h0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 9'h022, 18'h0, 1, 0, 9'h032, 18'h0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 9'h023, 18'h0, 1, 0, 9'h032, 18'h0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 9'h023, 18'h0, 0, 0, '0,     18'h0, 1, 0));
    repeat (4) vecs.push_back(idle());
    // A writes 0x010, B reads it back the very next cycle.
    vecs.push_back(mk(0, 1, 1, 9'h010, 18'h0AAA, 0, 0, '0,     '0,  1, 0));
    vecs.push_back(mk(0, 0, 0, '0,     '0,       1, 0, 9'h010, 18'h3, 0, 1));
    repeat (4) vecs.push_back(idle());

    foreach (vecs[i]) step(vecs[i]);

    // Read in flight dropped by a one-cycle reset; gnts held low during reset.
    step(mk(0, 1, 0, 9'h005, '0, 0, 0, '0, '0, 1, 0));
    step(mk(1, 1, 0, 9'h050, '0, 1, 0, 9'h051, '0, 0, 0));
    step(mk(0, 1, 0, 9'h050, '0, 1, 0, 9'h051, '0, 1, 0));
    step(mk(0, 0, 0, '0,     '0, 1, 0, 9'h051, '0, 0, 1));
    repeat (4) step(idle());

    // B alone reading four consecutive addresses.
    step(mk(0, 0, 0, '0, '0, 1, 0, 9'h040, '0, 0, 1));
    step(mk(0, 0, 0, '0, '0, 1, 0, 9'h041, '0, 0, 1));
    step(mk(0, 0, 0, '0, '0, 1, 0, 9'h042, '0, 0, 1));
    step(mk(0, 0, 0, '0, '0, 1, 0, 9'h043, '0, 0, 1));
    repeat (5) step(idle());

    if (exp_q2.size() != 0 || exp_q1.size() != 0) begin
      nChecks++;
      nFails++;
      $display("FAIL drain: %0d/%0d returns never seen, expected 0", exp_q2.size(), exp_q1.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
